// File: rtl/mips_pkg.sv
// Constants shared by the single-cycle MIPS datapath blocks: opcodes,
// data-memory responder state encoding and the error read value.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write, combinational read.
// Contents are not affected by reset and start at zero in simulation.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          write_en,
    input  logic [AW-1:0] index,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data
);

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[index] <= write_data;
        end
    end

    assign read_data = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the Mem_Read/Mem_Write handshake: accepts one word access,
// holds it LATENCY cycles, then pulses Mem_Ready (with Mem_Error if illegal).
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        Mem_Ready,
    output logic        Mem_Busy,
    output logic        Mem_Error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mem_state_t     state;
    logic [CW-1:0]  count;
    logic [AW-1:0]  req_index;
    logic [31:0]    req_data;
    logic           req_write;
    logic           req_err;
    logic           write_en;
    logic [31:0]    array_data;
    logic           misaligned;
    logic           out_of_range;
    logic           conflict;

    // Error flags are captured with the request so later input changes are irrelevant.
    assign misaligned   = |Address[1:0];
    assign out_of_range = |Address[31:AW+2];
    assign conflict     = Mem_Read & Mem_Write;

    assign write_en = (state == ST_WAIT) && (count == '0) && req_write && !req_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk       (Clock),
        .write_en  (write_en),
        .index     (req_index),
        .write_data(req_data),
        .read_data (array_data)
    );

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            req_index <= '0;
            req_data  <= '0;
            req_write <= 1'b0;
            req_err   <= 1'b0;
            Read_Data <= '0;
            Mem_Ready <= 1'b0;
            Mem_Busy  <= 1'b0;
            Mem_Error <= 1'b0;
        end else begin
            Mem_Ready <= 1'b0;
            Mem_Error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Mem_Read || Mem_Write) begin
                        req_index <= Address[AW+1:2];
                        req_data  <= Write_Data;
                        req_write <= Mem_Write;
                        req_err   <= misaligned | out_of_range | conflict;
                        count     <= CNT_LOAD;
                        Mem_Busy  <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        state     <= ST_RESP;
                        Mem_Ready <= 1'b1;
                        Mem_Error <= req_err;
                        if (req_err) begin
                            Read_Data <= ERR_DATA;
                        end else if (!req_write) begin
                            Read_Data <= array_data;
                        end
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    Mem_Busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    Mem_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle MIPS datapath. It is the memory end of the `Mem_Read`/`Mem_Write` interface that the main control unit drives for `lw` (opcode 35) and `sw` (opcode 43). It accepts one word access at a time and holds it for a fixed, parameterised latency. It then completes the access with a one-cycle `Mem_Ready` pulse, flagging misaligned, out-of-range or conflicting requests.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the memory. Must be a power of two, ≥ 4.
- `LATENCY`, 2: number of cycles from request acceptance until `Mem_Ready` is high. Must be ≥ 1.
- `Clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `Mem_Read`  in  1  read request strobe; held by the requester until `Mem_Ready`.
- `Mem_Write`  in  1  write request strobe; held by the requester until `Mem_Ready`.
- `Address`  in  32  byte address, word aligned (ALU result).
- `Write_Data`  in  32  store data (register-file `Read_Data_2`).
- `Read_Data`  out  32  load data; valid while `Mem_Ready`=1, then held.
- `Mem_Ready`  out  1  one-cycle completion pulse.
- `Mem_Busy`  out  1  high whenever a request is in flight (state ≠ IDLE).
- `Mem_Error`  out  1  asserted with `Mem_Ready` when the completed request was illegal.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - If `Mem_Read` or `Mem_Write` is high at a posedge, latch `Address`, `Write_Data`, the op and the error flags.
  - Load the counter with `LATENCY-1` and go to WAIT.
- **WAIT:**
  - Counter ≠ 0: decrement the counter.
  - Counter = 0: go to RESP. On this same edge, perform the array write (legal write), or register the array word into `Read_Data` (legal read).
- **RESP:** `Mem_Ready`=1 for exactly this cycle. Unconditionally return to IDLE on the next edge.
- Strobes are ignored in WAIT and RESP. A request is sampled only in IDLE.
- Error conditions are evaluated on the latched request:
  - `Address[1:0]` ≠ 0 (misaligned).
  - `Address[31:2]` ≥ `DEPTH_WORDS` (out of range).
  - `Mem_Read` and `Mem_Write` both high (conflict).
- Handling of an illegal request:
  - It still runs the full handshake with the same latency.
  - No array write occurs.
  - `Read_Data` is loaded with `ERR_DATA` (32'h00000000).
  - `Mem_Error`=1 in the RESP cycle.
- The word index is `Address[log2(DEPTH_WORDS)+1:2]`. There is no byte or halfword access.
- `Read_Data` keeps its last value after RESP. It changes only when the next read (or errored request) completes.
- Memory contents:
  - Not cleared by reset.
  - Initialised to zero at time 0 for simulation.
  - An optional `$readmemh` preload is allowed, guarded by a define.

## Timing
- Request sampled at edge N. Edge N+LATENCY enters RESP, so `Mem_Ready` is high between edges N+LATENCY and N+LATENCY+1.
- State returns to IDLE at edge N+LATENCY+1. The earliest next request is sampled at edge N+LATENCY+2, which gives a throughput of one access per LATENCY+2 cycles.
- A write becomes visible to a read that is sampled at or after edge N+LATENCY+2.
- `Mem_Busy` is high from edge N through edge N+LATENCY+1.
- Reset values: state=IDLE, counter=0, `Read_Data`=0, `Mem_Ready`=0, `Mem_Busy`=0, `Mem_Error`=0.
- Reset asserted mid-operation:
  - An immediate return to IDLE.
  - A pending write is discarded (the array is unchanged).
  - No `Mem_Ready` pulse.
- Deassertion of reset takes effect at the next posedge. The first request can be sampled at that edge.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants `OP_RTYPE`=0, `OP_LW`=35, `OP_SW`=43, `OP_ADDI`=8.
  - FSM state encoding (2 bits: IDLE=0, WAIT=1, RESP=2).
  - `ERR_DATA`.
- Sub-module `dmem_array`:
  - `DEPTH_WORDS`×32 storage.
  - Synchronous write enable and combinational read at the word index.
  - Instantiated once. The FSM, counter, latches and error logic stay in `data_mem_responder`.

## Test plan
- **Reset, idle and read-after-write:** reset held 3 cycles; then `sw` with `Address`=0x10, `Write_Data`=0xCAFEBABE, held until ready. Expected: `Mem_Busy` rises, `Mem_Ready` pulses once exactly 2 cycles after acceptance with `Mem_Error`=0. A later read of 0x10 returns 0xCAFEBABE with `Mem_Ready` one cycle wide.
- **Back-to-back with latency sweep:** LATENCY=1 and LATENCY=4. Write 0x11111111 to 0x0, then immediately read 0x0 with the strobe held continuously. Expected: the second request is accepted exactly LATENCY+2 edges after the first, and the read returns 0x11111111.
- **Misaligned access:** read at 0x13. Expected: `Mem_Ready`=1 with `Mem_Error`=1 and `Read_Data`=0. A write of 0xFFFFFFFF to 0x12 leaves words 4 and 5 unchanged.
- **Out-of-range and conflict:** `Address`=4×DEPTH_WORDS (0x400 at the default depth) flags an error. Both strobes high flags an error, and the array is unchanged on readback.
- **Reset mid-write:** start a write of 0xDEADBEEF to 0x20 and assert `reset` during WAIT. Expected: no `Mem_Ready`; all outputs 0 immediately; a subsequent read of 0x20 returns the prior value (0).
